// File: rtl/burst_pattern_gen_if.sv
// rtl/burst_pattern_gen_if.sv - control/config/lane bus for burst_pattern_gen
// Purpose: groups the segment-table write port, frame control and pulse-lane
//          outputs of burst_pattern_gen.
// Signals: cfg_we/cfg_addr/cfg_wdata  segment table write ({kind,len})
//          start/loop_en/stop         frame sequencing control
//          lane_mask                  per-lane output force-low
//                                     (BURST_PATTERN_LANE_MASK_EN only)
//          row_out/busy/frame_done/frame_cnt/cfg_err  generator outputs
// Modports: master drives control and config, slave is the generator.
interface burst_pattern_gen_if #(
  parameter int ROWS  = 7,
  parameter int DEPTH = 8,
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
);
  localparam int AW = $clog2(ROWS * DEPTH);

  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [LEN_W:0]   cfg_wdata;
  logic             start;
  logic             loop_en;
  logic             stop;
`ifdef BURST_PATTERN_LANE_MASK_EN
  logic [ROWS-1:0]  lane_mask;
`endif
  logic [ROWS-1:0]  row_out;
  logic             busy;
  logic             frame_done;
  logic [CNT_W-1:0] frame_cnt;
  logic             cfg_err;

  modport master (
`ifdef BURST_PATTERN_LANE_MASK_EN
    output lane_mask,
`endif
    output cfg_we, cfg_addr, cfg_wdata, start, loop_en, stop,
    input  row_out, busy, frame_done, frame_cnt, cfg_err
  );

  modport slave (
`ifdef BURST_PATTERN_LANE_MASK_EN
    input  lane_mask,
`endif
    input  cfg_we, cfg_addr, cfg_wdata, start, loop_en, stop,
    output row_out, busy, frame_done, frame_cnt, cfg_err
  );
endinterface

// File: rtl/burst_pattern_gen.sv
// rtl/burst_pattern_gen.sv - multi-lane run-length pulse-burst pattern generator
// Purpose: each of ROWS lanes plays a program of BURST/GAP segments from a
//          register-array segment table; frames optionally repeat with
//          FRAME_GAP idle-low cycles in between.
// Ports:   clk  rising-edge clock
//          rst  asynchronous active-high reset
//          bus  burst_pattern_gen_if.slave (config writes, start/loop_en/stop,
//               row_out, busy, frame_done, frame_cnt, cfg_err)
// Option:  BURST_PATTERN_LANE_MASK_EN adds bus.lane_mask, forcing masked
//          lanes' row_out low while they keep sequencing.
module burst_pattern_gen #(
  parameter int ROWS      = 7,
  parameter int DEPTH     = 8,
  parameter int LEN_W     = 8,
  parameter int FRAME_GAP = 60,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  burst_pattern_gen_if.slave bus
);
  localparam int ENTRIES = ROWS * DEPTH;
  localparam int AW      = $clog2(ENTRIES);
  localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW      = (FRAME_GAP > 1) ? $clog2(FRAME_GAP + 1) : 1;

  typedef enum logic [1:0] {T_IDLE, T_RUN, T_GAP} top_t;
  typedef enum logic [2:0] {L_IDLE, L_BURST_HI, L_BURST_LO, L_GAP, L_DONE} lane_t;

  logic [LEN_W:0]   seg_tab [ENTRIES];

  top_t             top_q, top_d;
  logic [GW-1:0]    gap_q;
  logic             stop_q;
  logic [ROWS-1:0]  row_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_frames_q;
  logic             err_q;

  lane_t            lane_q [ROWS];
  lane_t            lane_d [ROWS];
  logic [IW-1:0]    idx_q  [ROWS];
  logic [IW-1:0]    idx_d  [ROWS];
  logic [LEN_W-1:0] cnt_q  [ROWS];
  logic [LEN_W-1:0] cnt_d  [ROWS];

  logic             all_done;
  logic             busy;
  logic             cfg_ok;
  logic             load_lanes;
  logic             frame_end;
  logic [ROWS-1:0]  row_hi;

  // Segment table: software-loaded, never reset, writable only while idle.
  always_ff @(posedge clk) begin
    if (cfg_ok && bus.cfg_we && ({1'b0, bus.cfg_addr} < (AW + 1)'(ENTRIES)))
      seg_tab[bus.cfg_addr] <= bus.cfg_wdata;
  end

  // Top FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) top_q <= T_IDLE;
    else     top_q <= top_d;
  end

  // Top FSM: next state. A live stop in the final RUN cycle counts as latched.
  always_comb begin
    top_d = top_q;
    case (top_q)
      T_IDLE: if (bus.start) top_d = T_RUN;
      T_RUN:  if (all_done)
                top_d = (bus.loop_en && !stop_q && !bus.stop) ? T_GAP : T_IDLE;
      T_GAP:  if (gap_q == '0) top_d = T_RUN;
      default: top_d = T_IDLE;
    endcase
  end

  // Top FSM: outputs. Lanes (re)load index 0 on the edge that enters RUN.
  always_comb begin
    busy       = (top_q != T_IDLE);
    cfg_ok     = (top_q == T_IDLE);
    load_lanes = ((top_q == T_IDLE) && bus.start) || ((top_q == T_GAP) && (gap_q == '0));
    frame_end  = (top_q == T_RUN) && all_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_q        <= '0;
      stop_q       <= 1'b0;
      row_q        <= '0;
      done_q       <= 1'b0;
      cnt_frames_q <= '0;
      err_q        <= 1'b0;
    end else begin
      if (frame_end)
        gap_q <= GW'(FRAME_GAP - 1);
      else if ((top_q == T_GAP) && (gap_q != '0))
        gap_q <= gap_q - GW'(1);
      if (top_d == T_IDLE)
        stop_q <= 1'b0;
      else if (bus.stop)
        stop_q <= 1'b1;
`ifdef BURST_PATTERN_LANE_MASK_EN
      row_q <= row_hi & ~bus.lane_mask;
`else
      row_q <= row_hi;
`endif
      done_q       <= frame_end;
      cnt_frames_q <= cnt_frames_q + CNT_W'(frame_end);
      err_q        <= bus.cfg_we && !cfg_ok;
    end
  end

  // Lane FSMs: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < ROWS; l++) begin
        lane_q[l] <= L_IDLE;
        idx_q[l]  <= '0;
        cnt_q[l]  <= '0;
      end
    end else begin
      for (int l = 0; l < ROWS; l++) begin
        lane_q[l] <= lane_d[l];
        idx_q[l]  <= idx_d[l];
        cnt_q[l]  <= cnt_d[l];
      end
    end
  end

  // Lane FSMs: next state. The following segment is fetched in the same
  // cycle the current one ends so there is never an idle bubble.
  always_comb begin
    logic           seg_end;
    logic           fetch;
    logic [IW-1:0]  nidx;
    logic [AW-1:0]  raddr;
    logic [LEN_W:0] ent;
    for (int l = 0; l < ROWS; l++) begin
      lane_d[l] = lane_q[l];
      idx_d[l]  = idx_q[l];
      cnt_d[l]  = cnt_q[l];
      seg_end   = 1'b0;
      fetch     = 1'b0;
      nidx      = '0;
      case (lane_q[l])
        L_BURST_HI: lane_d[l] = L_BURST_LO;
        L_BURST_LO: begin
          if (cnt_q[l] == LEN_W'(1)) begin
            seg_end = 1'b1;
          end else begin
            cnt_d[l]  = cnt_q[l] - LEN_W'(1);
            lane_d[l] = L_BURST_HI;
          end
        end
        L_GAP: begin
          if (cnt_q[l] == LEN_W'(1)) seg_end = 1'b1;
          else                       cnt_d[l] = cnt_q[l] - LEN_W'(1);
        end
        default: ;
      endcase
      if (load_lanes) begin
        fetch = 1'b1;
        nidx  = '0;
      end else if (top_q == T_IDLE) begin
        lane_d[l] = L_IDLE;
      end else if (seg_end) begin
        // Last table slot finished: lane ends, it does not wrap to index 0.
        if (idx_q[l] == IW'(DEPTH - 1)) begin
          lane_d[l] = L_DONE;
        end else begin
          fetch = 1'b1;
          nidx  = idx_q[l] + IW'(1);
        end
      end
      raddr = AW'(l * DEPTH) + AW'(nidx);
      ent   = seg_tab[raddr];
      if (fetch) begin
        idx_d[l] = nidx;
        if (ent[LEN_W-1:0] == '0) begin
          lane_d[l] = L_DONE;
        end else begin
          cnt_d[l]  = ent[LEN_W-1:0];
          lane_d[l] = ent[LEN_W] ? L_BURST_HI : L_GAP;
        end
      end
    end
  end

  always_comb begin
    all_done = 1'b1;
    row_hi   = '0;
    for (int l = 0; l < ROWS; l++) begin
      if (lane_q[l] != L_DONE) all_done = 1'b0;
      row_hi[l] = (lane_q[l] == L_BURST_HI);
    end
  end

  assign bus.row_out    = row_q;
  assign bus.busy       = busy;
  assign bus.frame_done = done_q;
  assign bus.frame_cnt  = cnt_frames_q;
  assign bus.cfg_err    = err_q;
endmodule

// File: tb/tb_burst_pattern_gen.sv
// tb/tb_burst_pattern_gen.sv - self-checking bench for burst_pattern_gen
`timescale 1ns/1ps
module tb_burst_pattern_gen;
  localparam int ROWS      = 7;
  localparam int DEPTH     = 8;
  localparam int LEN_W     = 8;
  localparam int FRAME_GAP = 60;
  localparam int CNT_W     = 16;
  localparam int ENTRIES   = ROWS * DEPTH;
  localparam int AW        = $clog2(ENTRIES);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  burst_pattern_gen_if #(.ROWS(ROWS), .DEPTH(DEPTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  burst_pattern_gen #(
    .ROWS(ROWS), .DEPTH(DEPTH), .LEN_W(LEN_W), .FRAME_GAP(FRAME_GAP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;
  logic [LEN_W:0] mtab [ENTRIES];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: a lane is the concatenation of its segments up to len=0 or DEPTH.
  function automatic int seg_dur(input int l, input int i);
    int len;
    len = int'(mtab[l*DEPTH+i][LEN_W-1:0]);
    return mtab[l*DEPTH+i][LEN_W] ? 2 * len : len;
  endfunction

  function automatic int lane_dur(input int l);
    int d = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mtab[l*DEPTH+i][LEN_W-1:0] == '0) break;
      d += seg_dur(l, i);
    end
    return d;
  endfunction

  function automatic bit lane_bit(input int l, input int t);
    int rem = t;
    for (int i = 0; i < DEPTH; i++) begin
      if (mtab[l*DEPTH+i][LEN_W-1:0] == '0) return 1'b0;
      if (rem < seg_dur(l, i)) return mtab[l*DEPTH+i][LEN_W] && (rem % 2 == 0);
      rem -= seg_dur(l, i);
    end
    return 1'b0;
  endfunction

  task automatic clear_tab();
    for (int a = 0; a < ENTRIES; a++) mtab[a] = '0;
  endtask

  task automatic set_seg(input int l, input int i, input bit kind, input int len);
    mtab[l*DEPTH+i] = {kind, LEN_W'(len)};
  endtask

  task automatic push_tab();
    for (int a = 0; a < ENTRIES; a++) begin
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = AW'(a);
      bus.cfg_wdata = mtab[a];
      @(posedge clk);
      @(negedge clk);
    end
    bus.cfg_we = 1'b0;
  endtask

  // Starts a sequence and checks every cycle until a little past the last frame_done.
  task automatic run_frames(input string tag, input bit loop, input int nframes,
                            input bit stop_at_start, input bit bad_write);
    int d = 0;
    int period, base_last, endj, b;
    logic [ROWS-1:0] er;
    bit edone;
    for (int l = 0; l < ROWS; l++) if (lane_dur(l) > d) d = lane_dur(l);
    period    = d + 1 + FRAME_GAP;
    base_last = (nframes - 1) * period;
    endj      = base_last + d + 1;
    bus.start   = 1'b1;
    bus.loop_en = loop;
    bus.stop    = stop_at_start;
    @(posedge clk);
    @(negedge clk);
    for (int j = 0; j <= endj + 2; j++) begin
      er = '0;
      edone = 1'b0;
      for (int f = 0; f < nframes; f++) begin
        b = f * period;
        if (j > b && j <= b + d)
          for (int l = 0; l < ROWS; l++) er[l] = lane_bit(l, j - b - 1);
        if (j == b + d + 1) edone = 1'b1;
      end
      if (edone) exp_cnt++;
      check({tag, "/row_out"},    bus.row_out,    er);
      check({tag, "/frame_done"}, bus.frame_done, edone);
      check({tag, "/busy"},       bus.busy,       (j < endj));
      check({tag, "/cfg_err"},    bus.cfg_err,    (bad_write && j == 2));
      bus.cfg_we = 1'b0;
      bus.start  = 1'b0;
      bus.stop   = 1'b0;
      if (bad_write && j == 1) begin
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = ~mtab[0];
        bus.start     = 1'b1;
      end
      if (nframes > 1 && j == base_last) bus.stop = 1'b1;
      @(negedge clk);
    end
    bus.loop_en = 1'b0;
    check({tag, "/frame_cnt"}, bus.frame_cnt, CNT_W'(exp_cnt));
  endtask

  task automatic load_gsk();
    clear_tab();
    set_seg(0, 0, 1'b1, 3);
    set_seg(0, 1, 1'b0, 54);
    set_seg(0, 2, 1'b1, 3);
    push_tab();
  endtask

  initial begin
    int nseg, nfr;
    bit lp;
    rst           = 1'b1;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    bus.start     = 1'b0;
    bus.loop_en   = 1'b0;
    bus.stop      = 1'b0;
`ifdef BURST_PATTERN_LANE_MASK_EN
    bus.lane_mask = '0;
`endif
    repeat (3) @(negedge clk);
    check("reset/row_out",    bus.row_out,    0);
    check("reset/busy",       bus.busy,       0);
    check("reset/frame_done", bus.frame_done, 0);
    check("reset/frame_cnt",  bus.frame_cnt,  0);
    check("reset/cfg_err",    bus.cfg_err,    0);
    rst = 1'b0;
    @(negedge clk);

    load_gsk();
    run_frames("gsk_once", 1'b0, 1, 1'b0, 1'b0);
    run_frames("loop3",    1'b1, 3, 1'b0, 1'b0);
    run_frames("cfg_busy", 1'b0, 1, 1'b0, 1'b1);
    run_frames("replay",   1'b0, 1, 1'b0, 1'b0);
    run_frames("start_stop", 1'b1, 1, 1'b1, 1'b0);

    clear_tab();
    set_seg(1, 0, 1'b1, 24);
    set_seg(1, 1, 1'b0, 12);
    set_seg(1, 2, 1'b1, 24);
    push_tab();
    run_frames("lane1_b24", 1'b0, 1, 1'b0, 1'b0);

    clear_tab();
    for (int i = 0; i < DEPTH; i++) set_seg(3, i, i[0] == 1'b0, 2 + i);
    push_tab();
    run_frames("full_lane", 1'b0, 1, 1'b0, 1'b0);

    clear_tab();
    push_tab();
    run_frames("all_empty",  1'b0, 1, 1'b0, 1'b0);
    run_frames("empty_loop", 1'b1, 2, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a burst
    load_gsk();
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("mid_rst/pre_row0", bus.row_out[0], 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst/row_out",   bus.row_out,   0);
    check("mid_rst/busy",      bus.busy,      0);
    check("mid_rst/frame_cnt", bus.frame_cnt, 0);
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frames("after_rst", 1'b0, 1, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      clear_tab();
      for (int l = 0; l < ROWS; l++) begin
        nseg = $urandom_range(0, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
          if (i < nseg)       set_seg(l, i, $urandom_range(0, 1) == 1, $urandom_range(1, 12));
          else if (i == nseg) set_seg(l, i, $urandom_range(0, 1) == 1, 0);
          else                set_seg(l, i, $urandom_range(0, 1) == 1, $urandom_range(1, 12));
        end
      end
      push_tab();
      lp  = ($urandom_range(0, 1) == 1);
      nfr = lp ? $urandom_range(1, 3) : 1;
      run_frames($sformatf("rand%0d", r), lp, nfr, lp && (nfr == 1), $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/burst_pattern_gen.md
Name: burst_pattern_gen

Overview:
Synthesizable source for the multi-row pulse-burst patterns used to render glyph rows (e.g. "GSK") on a ROWS-lane display bus. Each lane plays a run-length program of BURST and GAP segments from an internal segment table. It sits directly upstream of the row-waveform consumer and drives one pulse lane per display row. Frames repeat with a programmable inter-frame gap.

Parameters:
ROWS, 7, number of output lanes (display rows)
DEPTH, 8, segment entries per lane
LEN_W, 8, segment length field width
FRAME_GAP, 60, idle-low cycles between looped frames (>=1)
CNT_W, 16, frame counter width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
cfg_we  in  1  segment table write strobe
cfg_addr  in  $clog2(ROWS*DEPTH)  table address = lane*DEPTH + index
cfg_wdata  in  LEN_W+1  {kind, len}; kind 1=BURST, 0=GAP
start  in  1  begin frame sequence (accepted in IDLE only)
loop_en  in  1  repeat frames after FRAME_GAP
stop  in  1  finish current frame, then IDLE
row_out  out  ROWS  registered pulse lanes
busy  out  1  high in RUN or GAP
frame_done  out  1  one-cycle pulse at each frame end
frame_cnt  out  CNT_W  completed frames, wraps at 2^CNT_W
cfg_err  out  1  one-cycle pulse: write attempted while busy (write dropped)

Behaviour:
- Reset (async): row_out=0, busy=0, frame_done=0, frame_cnt=0, cfg_err=0, top FSM=IDLE, all lanes L_IDLE. Table contents are not reset; software loads them.
- Segment: len=0 is the end-of-lane marker (kind ignored). BURST len n = n repetitions of (1 cycle high, 1 cycle low), i.e. 2n cycles. GAP len m = m cycles low.
- Table read is combinational (register array). A lane loads its next segment in the same cycle the current one ends. No bubbles: lane duration = sum(2n) + sum(m).
- Top FSM: IDLE -> RUN on start. RUN -> (all lanes done) -> GAP if loop_en && !stop_latched, else IDLE. GAP counts FRAME_GAP cycles with all row_out low, then RUN and lanes restart at index 0.
- stop is latched while busy and cleared on entering IDLE. start is ignored while busy.
- Lane FSM: L_IDLE, L_BURST_HI, L_BURST_LO, L_GAP, L_DONE. On RUN entry, each lane fetches index 0. A lane walks indices upward and enters L_DONE on len=0, or after finishing index DEPTH-1 (no wrap). In L_DONE its row_out stays 0.
- Timing: edge k samples start. row_out reflects segment 0 of each lane from edge k+1. Example: BURST 3 gives high in cycles k+1, k+3, k+5.
- Frame end: the cycle after the last lane reaches L_DONE, frame_done=1 and frame_cnt increments. busy drops in that same cycle if returning to IDLE.
- Empty lane (index 0 len=0): L_DONE immediately. If all lanes are empty, the frame lasts 1 cycle.
- cfg writes are accepted only in IDLE. Otherwise the write is ignored and cfg_err pulses the next cycle.
- stop and start asserted together in IDLE: the frame runs once, then IDLE.

Optional Feature:
BURST_PATTERN_LANE_MASK_EN: adds input lane_mask[ROWS-1:0]. A masked lane still sequences and counts toward frame completion, but its row_out is forced 0 (registered, one-cycle effect). Without the macro the port is absent and all lanes drive normally.

Test Plan:
- Lane0 {BURST 3, GAP 54, BURST 3, END}, start at edge k, loop_en=0 -> lane0 high exactly at k+1,k+3,k+5 and k+61,k+63,k+65; frame_done at k+67; frame_cnt=1; busy=0 after.
- Lane1 {BURST 24, GAP 12, BURST 24, END}, lane2 empty -> 24+24 pulses on lane1, lane2 always 0, frame_done one cycle after lane1 completes (cycle k+109).
- loop_en=1, FRAME_GAP=60, 3 frames then stop -> each frame is followed by exactly 60 low cycles, frame_cnt=3 after stop, busy falls with the third frame_done.
- cfg_we during RUN -> cfg_err pulse, table unchanged (replayed frame identical).
- Lane full with DEPTH entries and no terminator -> lane done after index 7, no wrap to 0.
- Assert rst mid-burst -> row_out=0 and busy=0 immediately (async). After release, the next start replays from index 0.
